// File: rtl/dech38_seq_if.sv
// Handshake and decoder-drive bundle between the controller and dech38_seq.
interface dech38_seq_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               abort;
  logic [2:0]         first;
  logic [2:0]         last;
  logic [DWELL_W-1:0] dwell;
  logic               a;
  logic               b;
  logic               c;
  logic               en;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, first, last, dwell,
    input  a, b, c, en, busy, done
  );

  modport slave (
    input  start, abort, first, last, dwell,
    output a, b, c, en, busy, done
  );
endinterface

// File: rtl/dech38_seq.sv
// Strobe-phase sequencer feeding a 3-to-8 decoder: walks codes first..last (mod 8),
// holding each for dwell+1 cycles. Define DECH38_SEQ_GAP_EN to insert a disabled gap between codes.
module dech38_seq #(
  parameter int DWELL_W = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  dech38_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
`ifdef DECH38_SEQ_GAP_EN
  localparam logic [1:0] ST_GAP  = 2'd3;
`endif

  logic [1:0]         state_r, state_s;
  logic [2:0]         code_r, code_s;
  logic [2:0]         last_r, last_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [DWELL_W-1:0] cnt_r, cnt_s;
  logic               en_r, en_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_s = state_r;
    code_s  = code_r;
    last_s  = last_r;
    dwell_s = dwell_r;
    cnt_s   = cnt_r;
    en_s    = en_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_s = ST_RUN;
          code_s  = bus.first;
          last_s  = bus.last;
          dwell_s = bus.dwell;
          cnt_s   = '0;
          en_s    = 1'b0;
          busy_s  = 1'b1;
        end else begin
          en_s    = 1'b1;
          busy_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          en_s    = 1'b1;
          busy_s  = 1'b0;
        end else if (cnt_r == dwell_r) begin
          cnt_s = '0;
          if (code_r == last_r) begin
            state_s = ST_FIN;
            en_s    = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            code_s = code_r + 3'd1;
`ifdef DECH38_SEQ_GAP_EN
            // Code moves while the decoder is disabled, re-enabled one cycle later.
            state_s = ST_GAP;
            en_s    = 1'b1;
`endif
          end
        end else begin
          cnt_s = cnt_r + DWELL_W'(1);
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
        en_s    = 1'b1;
        busy_s  = 1'b0;
      end
`ifdef DECH38_SEQ_GAP_EN
      ST_GAP: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          en_s    = 1'b1;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_RUN;
          en_s    = 1'b0;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        en_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      code_r  <= 3'd0;
      last_r  <= 3'd0;
      dwell_r <= '0;
      cnt_r   <= '0;
      en_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      code_r  <= code_s;
      last_r  <= last_s;
      dwell_r <= dwell_s;
      cnt_r   <= cnt_s;
      en_r    <= en_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.a    = code_r[0];
  assign bus.b    = code_r[1];
  assign bus.c    = code_r[2];
  assign bus.en   = en_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: doc/dech38_seq.md
Name: dech38_seq

Overview:
- Strobe-phase sequencer that sits directly upstream of the 3-to-8 decoder in TOM.
- Drives the decoder's select lines (a, b, c) and its active-low enable (en), walking a programmable range of codes.
- Holds each code for a programmable dwell, so the decoder emits one-hot strobes in sequence.
- Provides a start/busy/done handshake to the controlling logic, plus an abort.

Parameters:
- DWELL_W, 4, width of the dwell field; each code is held dwell+1 cycles (1..2^DWELL_W).

Ports:
- sys_clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sequence; sampled only in IDLE.
- abort  input  1  terminate the sequence immediately; no done pulse.
- first  input  3  first code of the sequence; latched on accepted start.
- last  input  3  last code of the sequence; latched on accepted start.
- dwell  input  DWELL_W  hold count per code; latched on accepted start.
- a  output  1  select bit 0 to the decoder.
- b  output  1  select bit 1 to the decoder.
- c  output  1  select bit 2 to the decoder.
- en  output  1  decoder enable, active-low (0 = decoder outputs live).
- busy  output  1  high from the cycle after an accepted start until the sequence ends.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: one clock, sys_clk; reset is synchronous and active-high.
- Reset values: a=b=c=0, en=1, busy=0, done=0; state IDLE; latched first/last/dwell and the dwell counter cleared.
- Reset mid-sequence: returns to IDLE on the next edge with no done pulse.
- All outputs are registered. {c,b,a} is the current 3-bit code.
- States:
  - IDLE: en=1, busy=0, {c,b,a} holds its last value. An accepted start moves to RUN.
  - RUN: en=0, busy=1.
  - FIN: en=1, busy=0, done=1 for one cycle, then IDLE.
- Accepted start: start=1 && abort=0 in IDLE. On the next edge: latch first/last/dwell, {c,b,a}=first, en=0, busy=1, dwell counter=0.
- Latency: start to first decoder strobe is 1 cycle.
- Dwell in RUN: the counter increments each cycle. When it equals the latched dwell, the current code has been held dwell+1 cycles, and:
  - code==last: go to FIN; en=1 on the same edge.
  - otherwise: code = code+1 mod 8; the counter clears.
- Wrap-around: allowed. Number of codes visited = ((last-first) mod 8)+1.
  - first==last: single code.
  - first=6, last=1: visits 6,7,0,1.
- Sequence length: first strobe to done = N*(dwell+1) cycles, where N is the number of codes. done is asserted the cycle after the last strobe cycle.
- Abort in RUN: next edge goes to IDLE, en=1, busy=0, done=0. {c,b,a} holds.
- Simultaneous start and abort in IDLE: abort wins; start is ignored.
- start while RUN or FIN: ignored; there is no queuing.
- Input stability: input changes during RUN have no effect, because the values were latched at start.
- Glitch freedom: en and {c,b,a} change on the same edge only when en goes from 1 to 0 (start) or from 0 to 1 (end). Code changes while en=0 rely on the decoder's combinational settling, unless the optional feature below is compiled in.

Optional Feature:
- Macro: DECH38_SEQ_GAP_EN.
- Defined:
  - Between consecutive codes, insert one GAP cycle with en=1 and busy=1.
  - {c,b,a} advances to the next code on the edge entering GAP; en returns to 0 on the following edge.
  - No gap is inserted before the first code or after the last.
  - Total length becomes N*(dwell+1)+(N-1).
  - abort during GAP goes to IDLE as in RUN.
- Not defined: no GAP state exists; codes advance back to back with en held 0 throughout RUN.

Test Plan:
- Reset, then idle 5 cycles: a=b=c=0, en=1, busy=0, done=0 throughout.
- start with first=2, last=4, dwell=1: {c,b,a}=2,2,3,3,4,4 with en=0 for 6 cycles, then en=1 and done=1 for one cycle; busy high for exactly those 6 cycles.
- Wrap: first=6, last=1, dwell=0: codes 6,7,0,1 on 4 consecutive cycles, then done. Single code: first=last=5, dwell=3: code 5 for 4 cycles, then done.
- Abort on the 2nd cycle of code 3 in the sequence first=2, last=4, dwell=1: next cycle en=1, busy=0, no done pulse. A start pulse during RUN is ignored, and start together with abort in IDLE stays IDLE.
- Reset asserted mid-RUN: next cycle all outputs at reset values; a following start behaves normally.
- With DECH38_SEQ_GAP_EN, first=0, last=2, dwell=0: en pattern is 0,1,0,1,0, with codes 0,1,1,2,2; done on the cycle after, total busy of 5 cycles.
